// File: rtl/cci_mpf_shim_buffer_afu_pkg.sv
// CCI-P request/response types shared by the AFU-side buffer, its interface and its FIFOs.
// Tx channels carry a valid bit inside the struct; c2 and Rx never pass through storage.
package cci_mpf_shim_buffer_afu_pkg;

  localparam int CCIP_ADDR_W   = 42;
  localparam int CCIP_MDATA_W  = 16;
  localparam int CCIP_CLDATA_W = 64;

  typedef struct packed {
    logic [3:0]              req_type;
    logic [CCIP_ADDR_W-1:0]  address;
    logic [CCIP_MDATA_W-1:0] mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [3:0]              req_type;
    logic [CCIP_ADDR_W-1:0]  address;
    logic [CCIP_MDATA_W-1:0] mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr       hdr;
    logic [CCIP_CLDATA_W-1:0] data;
    logic                     valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [8:0]  tid;
    logic        mmio_rd_valid;
    logic [63:0] data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    logic [CCIP_MDATA_W-1:0]  mdata;
    logic [3:0]               resp_type;
    logic [CCIP_CLDATA_W-1:0] data;
    logic                     rsp_valid;
    logic                     mmio_rd_valid;
    logic                     mmio_wr_valid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [CCIP_MDATA_W-1:0] mdata;
    logic [3:0]              resp_type;
    logic                    rsp_valid;
  } t_if_ccip_c1_Rx;

endpackage

// File: rtl/cci_mpf_shim_buffer_afu_if.sv
// One CCI-P/MPF port: Tx requests flow toward the FIU, almost-full and Rx flow back.
// to_afu is the view of whoever faces the AFU; to_fiu is the view of whoever faces the FIU.
interface cci_mpf_if;
  import cci_mpf_shim_buffer_afu_pkg::*;

  logic           reset;
  t_if_ccip_c0_Tx c0Tx;
  t_if_ccip_c1_Tx c1Tx;
  t_if_ccip_c2_Tx c2Tx;
  logic           c0TxAlmFull;
  logic           c1TxAlmFull;
  t_if_ccip_c0_Rx c0Rx;
  t_if_ccip_c1_Rx c1Rx;

  modport to_afu (
    input  reset, c0Tx, c1Tx, c2Tx,
    output c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
  );

  modport to_fiu (
    output reset, c0Tx, c1Tx, c2Tx,
    input  c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
  );

endinterface

// File: rtl/cci_mpf_shim_buffer_afu_fifo.sv
// Small FIFO with a stable head and a registered almost-full (fires when free slots <= THRESHOLD).
// Enqueue is visible at the head one cycle later; enq while full is dropped unless paired with a deq.
module cci_mpf_prim_fifo_lutram #(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 12,
  parameter int THRESHOLD   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_DATA_BITS-1:0] enq_dat,
  input  logic                   enq_vld,
  output logic                   not_full,
  output logic                   alm_full,
  output logic [N_DATA_BITS-1:0] first,
  input  logic                   deq,
  output logic                   not_empty
);
  localparam int CNT_W = $clog2(N_ENTRIES + 1);
  localparam int PTR_W = $clog2(N_ENTRIES);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_ENTRIES - 1);

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic                   enq_ok;
  logic                   deq_ok;

  assign not_empty  = (count != '0);
  assign not_full   = (count != CNT_W'(N_ENTRIES));
  assign deq_ok     = deq & not_empty;
  // A full FIFO still accepts an enqueue when the head leaves in the same cycle.
  assign enq_ok     = enq_vld & (not_full | deq_ok);
  assign count_next = count + CNT_W'(enq_ok) - CNT_W'(deq_ok);
  assign first      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      alm_full <= 1'b1;
    end else begin
      if (enq_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (deq_ok) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      count    <= count_next;
      alm_full <= ((N_ENTRIES - int'(count_next)) <= THRESHOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok && !reset) mem[wr_ptr] <= enq_dat;
  end

endmodule

// File: rtl/cci_mpf_shim_buffer_afu.sv
// AFU-side request buffer: c0/c1 Tx absorbed into FIFOs popped by the parent, almost-full toward the AFU.
// Head appears 1 cycle after enqueue (2 with REGISTER_INBOUND); c2Tx and Rx are plain wires.
module cci_mpf_shim_buffer_afu
  import cci_mpf_shim_buffer_afu_pkg::*;
#(
  parameter int N_ENTRIES        = 12,
  parameter int THRESHOLD        = 8,
  parameter int REGISTER_INBOUND = 0
) (
  input  logic      clk,
  cci_mpf_if.to_afu afu_raw,
  cci_mpf_if.to_fiu afu_buf,
  input  logic      deqC0Tx,
  input  logic      deqC1Tx
);
  localparam int ALM_THRESHOLD = THRESHOLD + ((REGISTER_INBOUND != 0) ? 1 : 0);

  logic           reset;
  t_if_ccip_c0_Tx c0_in;
  t_if_ccip_c1_Tx c1_in;
  t_if_ccip_c0_Tx c0_head;
  t_if_ccip_c1_Tx c1_head;
  t_if_ccip_c0_Tx c0_out;
  t_if_ccip_c1_Tx c1_out;
  logic           c0_not_empty, c1_not_empty;
  logic           c0_not_full, c1_not_full;
  logic           c0_alm_full, c1_alm_full;
  logic           unused_buf_alm_full;

  assign reset         = afu_raw.reset;
  assign afu_buf.reset = reset;

  generate
    if (REGISTER_INBOUND != 0) begin : g_reg_in
      always_ff @(posedge clk) begin
        if (reset) begin
          c0_in <= '0;
          c1_in <= '0;
        end else begin
          c0_in <= afu_raw.c0Tx;
          c1_in <= afu_raw.c1Tx;
        end
      end
    end else begin : g_wire_in
      assign c0_in = afu_raw.c0Tx;
      assign c1_in = afu_raw.c1Tx;
    end
  endgenerate

  cci_mpf_prim_fifo_lutram #(
    .N_DATA_BITS ($bits(t_if_ccip_c0_Tx)),
    .N_ENTRIES   (N_ENTRIES),
    .THRESHOLD   (ALM_THRESHOLD)
  ) u_fifo_c0 (
    .clk       (clk),
    .reset     (reset),
    .enq_dat   (c0_in),
    .enq_vld   (c0_in.valid),
    .not_full  (c0_not_full),
    .alm_full  (c0_alm_full),
    .first     (c0_head),
    .deq       (deqC0Tx),
    .not_empty (c0_not_empty)
  );

  cci_mpf_prim_fifo_lutram #(
    .N_DATA_BITS ($bits(t_if_ccip_c1_Tx)),
    .N_ENTRIES   (N_ENTRIES),
    .THRESHOLD   (ALM_THRESHOLD)
  ) u_fifo_c1 (
    .clk       (clk),
    .reset     (reset),
    .enq_dat   (c1_in),
    .enq_vld   (c1_in.valid),
    .not_full  (c1_not_full),
    .alm_full  (c1_alm_full),
    .first     (c1_head),
    .deq       (deqC1Tx),
    .not_empty (c1_not_empty)
  );

  // Stored valid bit is stale once popped; occupancy is the authority.
  always_comb begin
    c0_out       = c0_head;
    c0_out.valid = c0_not_empty;
    c1_out       = c1_head;
    c1_out.valid = c1_not_empty;
  end

  assign afu_buf.c0Tx        = c0_out;
  assign afu_buf.c1Tx        = c1_out;
  assign afu_buf.c2Tx        = afu_raw.c2Tx;
  assign afu_raw.c0Rx        = afu_buf.c0Rx;
  assign afu_raw.c1Rx        = afu_buf.c1Rx;
  assign afu_raw.c0TxAlmFull = c0_alm_full | reset;
  assign afu_raw.c1TxAlmFull = c1_alm_full | reset;

  // The parent gates its own pops with the FIU-side almost-full; the buffer does not look at it.
  assign unused_buf_alm_full = afu_buf.c0TxAlmFull ^ afu_buf.c1TxAlmFull;

  a_c0_overflow: assert property (@(posedge clk) disable iff (reset)
    !(c0_in.valid && !c0_not_full && !deqC0Tx));
  a_c1_overflow: assert property (@(posedge clk) disable iff (reset)
    !(c1_in.valid && !c1_not_full && !deqC1Tx));
  a_c0_underflow: assert property (@(posedge clk) disable iff (reset)
    deqC0Tx |-> c0_not_empty);
  a_c1_underflow: assert property (@(posedge clk) disable iff (reset)
    deqC1Tx |-> c1_not_empty);

endmodule

// File: tb/tb_cci_mpf_shim_buffer_afu.sv
// Directed bench for cci_mpf_shim_buffer_afu: one instance unregistered, one with REGISTER_INBOUND=1.
module tb_cci_mpf_shim_buffer_afu;
  import cci_mpf_shim_buffer_afu_pkg::*;

  logic clk;
  logic d0c0, d0c1, d1c0, d1c1;
  int   tests  = 0;
  int   failed = 0;

  cci_mpf_if raw0 ();
  cci_mpf_if buf0 ();
  cci_mpf_if raw1 ();
  cci_mpf_if buf1 ();

  cci_mpf_shim_buffer_afu #(.N_ENTRIES(12), .THRESHOLD(8), .REGISTER_INBOUND(0)) dut0 (
    .clk(clk), .afu_raw(raw0), .afu_buf(buf0), .deqC0Tx(d0c0), .deqC1Tx(d0c1)
  );

  cci_mpf_shim_buffer_afu #(.N_ENTRIES(12), .THRESHOLD(8), .REGISTER_INBOUND(1)) dut1 (
    .clk(clk), .afu_raw(raw1), .afu_buf(buf1), .deqC0Tx(d1c0), .deqC1Tx(d1c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic t_if_ccip_c0_Tx mk_c0(input int id);
    t_if_ccip_c0_Tx r;
    r.hdr.req_type = 4'h1;
    r.hdr.address  = 42'h100 + 42'(id) * 42'd64;
    r.hdr.mdata    = 16'(id) ^ 16'hA5A5;
    r.valid        = 1'b1;
    return r;
  endfunction

  function automatic t_if_ccip_c1_Tx mk_c1(input int id);
    t_if_ccip_c1_Tx r;
    r.hdr.req_type = 4'h2;
    r.hdr.address  = 42'h8000 + 42'(id);
    r.hdr.mdata    = 16'(id);
    r.data         = {32'(id), 32'h5A5A0000 ^ 32'(id)};
    r.valid        = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 = dut0 c0, 1 = dut0 c1, 2 = dut1 c0. Pops one entry per cycle while the head is valid.
  task automatic drain(input int sel, input int first_id, input int exp_n, input string nm);
    int n = 0;
    for (int k = 0; k < 32; k++) begin
      logic v;
      logic ok;
      logic [15:0] got_md;
      case (sel)
        0: begin v = buf0.c0Tx.valid; ok = (buf0.c0Tx === mk_c0(first_id + n)); got_md = buf0.c0Tx.hdr.mdata; end
        1: begin v = buf0.c1Tx.valid; ok = (buf0.c1Tx === mk_c1(first_id + n)); got_md = buf0.c1Tx.hdr.mdata; end
        default: begin v = buf1.c0Tx.valid; ok = (buf1.c0Tx === mk_c0(first_id + n)); got_md = buf1.c0Tx.hdr.mdata; end
      endcase
      if (v !== 1'b1) break;
      tests++;
      if (!ok) begin
        failed++;
        $display("FAIL %s head %0d: got mdata %h, expected request id %0d", nm, n, got_md, first_id + n);
      end
      case (sel)
        0: d0c0 = 1'b1;
        1: d0c1 = 1'b1;
        default: d1c0 = 1'b1;
      endcase
      tick();
      d0c0 = 1'b0; d0c1 = 1'b0; d1c0 = 1'b0;
      n++;
    end
    tests++;
    if (n !== exp_n) begin
      failed++;
      $display("FAIL %s drained count: got %0d, expected %0d", nm, n, exp_n);
    end
  endtask

  task automatic test_reset();
    raw0.reset = 1'b1; raw1.reset = 1'b1;
    tick(); tick();
    tests++; if (buf0.c0Tx.valid !== 1'b0 || buf0.c1Tx.valid !== 1'b0) begin failed++;
      $display("FAIL reset_valid0: got %b%b, expected 00", buf0.c0Tx.valid, buf0.c1Tx.valid); end
    tests++; if (raw0.c0TxAlmFull !== 1'b1 || raw0.c1TxAlmFull !== 1'b1) begin failed++;
      $display("FAIL reset_almfull_in_reset: got %b%b, expected 11", raw0.c0TxAlmFull, raw0.c1TxAlmFull); end
    tests++; if (buf0.reset !== 1'b1 || buf1.reset !== 1'b1) begin failed++;
      $display("FAIL reset_forward: got %b%b, expected 11", buf0.reset, buf1.reset); end
    raw0.reset = 1'b0; raw1.reset = 1'b0;
    #1;
    tests++; if (raw0.c0TxAlmFull !== 1'b1 || raw1.c0TxAlmFull !== 1'b1) begin failed++;
      $display("FAIL reset_almfull_first_cycle: got %b%b, expected 11", raw0.c0TxAlmFull, raw1.c0TxAlmFull); end
    tests++; if (buf0.reset !== 1'b0) begin failed++;
      $display("FAIL reset_forward_low: got %b, expected 0", buf0.reset); end
    tick();
    tests++; if ({raw0.c0TxAlmFull, raw0.c1TxAlmFull, raw1.c0TxAlmFull, raw1.c1TxAlmFull} !== 4'b0000) begin failed++;
      $display("FAIL reset_almfull_settled: got %b%b%b%b, expected 0000",
               raw0.c0TxAlmFull, raw0.c1TxAlmFull, raw1.c0TxAlmFull, raw1.c1TxAlmFull); end
    tests++; if (buf1.c0Tx.valid !== 1'b0) begin failed++;
      $display("FAIL reset_valid1: got %b, expected 0", buf1.c0Tx.valid); end
  endtask

  task automatic test_single();
    raw0.c0Tx = mk_c0(7);
    tick();
    raw0.c0Tx = '0;
    tests++; if (buf0.c0Tx !== mk_c0(7)) begin failed++;
      $display("FAIL single_head: got %h, expected %h", buf0.c0Tx, mk_c0(7)); end
    tests++; if (raw0.c0TxAlmFull !== 1'b0) begin failed++;
      $display("FAIL single_almfull: got %b, expected 0", raw0.c0TxAlmFull); end
    d0c0 = 1'b1;
    tick();
    d0c0 = 1'b0;
    tests++; if (buf0.c0Tx.valid !== 1'b0) begin failed++;
      $display("FAIL single_pop: got valid %b, expected 0", buf0.c0Tx.valid); end
  endtask

  task automatic test_passthrough();
    t_if_ccip_c2_Tx c2;
    t_if_ccip_c0_Rx r0;
    t_if_ccip_c1_Rx r1;
    raw0.c0Tx = mk_c0(500);
    tick();
    raw0.c0Tx = '0;
    for (int p = 0; p < 2; p++) begin
      c2 = (p == 0) ? {9'h1A5, 1'b1, 64'hCAFEF00D12345678} : {9'h04B, 1'b0, 64'h0123456789ABCDEF};
      r0 = (p == 0) ? {16'hBEEF, 4'h3, 64'hFEEDFACE00C0FFEE, 1'b1, 1'b0, 1'b1}
                    : {16'h1234, 4'hC, 64'h0000000011110000, 1'b0, 1'b1, 1'b0};
      r1 = (p == 0) ? {16'h00A1, 4'h5, 1'b1} : {16'hF00F, 4'hA, 1'b0};
      raw0.c2Tx = c2; buf0.c0Rx = r0; buf0.c1Rx = r1;
      #1;
      tests++; if (buf0.c2Tx !== c2) begin failed++;
        $display("FAIL pass_c2Tx[%0d]: got %h, expected %h", p, buf0.c2Tx, c2); end
      tests++; if (raw0.c0Rx !== r0) begin failed++;
        $display("FAIL pass_c0Rx[%0d]: got %h, expected %h", p, raw0.c0Rx, r0); end
      tests++; if (raw0.c1Rx !== r1) begin failed++;
        $display("FAIL pass_c1Rx[%0d]: got %h, expected %h", p, raw0.c1Rx, r1); end
    end
    raw0.c2Tx = '0; buf0.c0Rx = '0; buf0.c1Rx = '0;
    drain(0, 500, 1, "pass_c0_head");
  endtask

  task automatic test_burst_fill();
    for (int i = 0; i < 4; i++) begin
      raw0.c1Tx = mk_c1(i);
      tick();
      if (i == 2) begin
        tests++; if (raw0.c1TxAlmFull !== 1'b0) begin failed++;
          $display("FAIL burst_almfull_at3: got %b, expected 0", raw0.c1TxAlmFull); end
      end
    end
    tests++; if (raw0.c1TxAlmFull !== 1'b1) begin failed++;
      $display("FAIL burst_almfull_at4: got %b, expected 1", raw0.c1TxAlmFull); end
    for (int i = 4; i < 12; i++) begin
      raw0.c1Tx = mk_c1(i);
      tick();
    end
    raw0.c1Tx = '0;
    tests++; if (raw0.c1TxAlmFull !== 1'b1 || buf0.c1Tx.valid !== 1'b1) begin failed++;
      $display("FAIL burst_full_state: almfull %b valid %b, expected 1 1", raw0.c1TxAlmFull, buf0.c1Tx.valid); end
    drain(1, 0, 12, "burst_drain");
    tests++; if (raw0.c1TxAlmFull !== 1'b0) begin failed++;
      $display("FAIL burst_almfull_after_drain: got %b, expected 0", raw0.c1TxAlmFull); end
  endtask

  task automatic test_steady_state();
    int nexp = 100;
    int nissue = 100;
    for (int i = 0; i < 4; i++) begin
      raw0.c1Tx = mk_c1(nissue++);
      tick();
    end
    for (int cyc = 0; cyc < 100; cyc++) begin
      tests++; if (raw0.c1TxAlmFull !== 1'b1) begin failed++;
        $display("FAIL steady_almfull cyc %0d: got %b, expected 1", cyc, raw0.c1TxAlmFull); end
      tests++; if (buf0.c1Tx !== mk_c1(nexp)) begin failed++;
        $display("FAIL steady_head cyc %0d: got mdata %h, expected id %0d", cyc, buf0.c1Tx.hdr.mdata, nexp); end
      raw0.c1Tx = mk_c1(nissue++);
      d0c1 = 1'b1;
      tick();
      nexp++;
    end
    raw0.c1Tx = '0;
    d0c1 = 1'b0;
    drain(1, nexp, 4, "steady_residual");
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 6; i++) begin
      raw0.c0Tx = mk_c0(200 + i);
      tick();
    end
    raw0.c0Tx = mk_c0(299);
    raw0.reset = 1'b1;
    #1;
    tests++; if (raw0.c0TxAlmFull !== 1'b1) begin failed++;
      $display("FAIL midrst_almfull_during: got %b, expected 1", raw0.c0TxAlmFull); end
    tick();
    raw0.reset = 1'b0;
    raw0.c0Tx = '0;
    #1;
    tests++; if (buf0.c0Tx.valid !== 1'b0) begin failed++;
      $display("FAIL midrst_valid: got %b, expected 0", buf0.c0Tx.valid); end
    tests++; if (raw0.c0TxAlmFull !== 1'b1) begin failed++;
      $display("FAIL midrst_almfull_hold: got %b, expected 1", raw0.c0TxAlmFull); end
    tick();
    tests++; if (raw0.c0TxAlmFull !== 1'b0 || buf0.c0Tx.valid !== 1'b0) begin failed++;
      $display("FAIL midrst_after: almfull %b valid %b, expected 0 0", raw0.c0TxAlmFull, buf0.c0Tx.valid); end
    raw0.c0Tx = mk_c0(300);
    tick();
    raw0.c0Tx = '0;
    drain(0, 300, 1, "midrst_fresh");
  endtask

  task automatic test_register_inbound();
    raw1.c0Tx = mk_c0(400);
    tick();
    raw1.c0Tx = '0;
    tests++; if (buf1.c0Tx.valid !== 1'b0) begin failed++;
      $display("FAIL ri_latency_1cyc: got valid %b, expected 0", buf1.c0Tx.valid); end
    tick();
    tests++; if (buf1.c0Tx !== mk_c0(400)) begin failed++;
      $display("FAIL ri_latency_2cyc: got %h, expected %h", buf1.c0Tx, mk_c0(400)); end
    drain(2, 400, 1, "ri_single");
    for (int i = 0; i < 3; i++) begin
      raw1.c0Tx = mk_c0(410 + i);
      tick();
    end
    raw1.c0Tx = '0;
    tests++; if (raw1.c0TxAlmFull !== 1'b0) begin failed++;
      $display("FAIL ri_almfull_at2: got %b, expected 0", raw1.c0TxAlmFull); end
    tick();
    tests++; if (raw1.c0TxAlmFull !== 1'b1) begin failed++;
      $display("FAIL ri_almfull_at3: got %b, expected 1", raw1.c0TxAlmFull); end
    for (int i = 3; i < 12; i++) begin
      raw1.c0Tx = mk_c0(410 + i);
      tick();
    end
    raw1.c0Tx = '0;
    tick();
    tests++; if (raw1.c0TxAlmFull !== 1'b1) begin failed++;
      $display("FAIL ri_almfull_full: got %b, expected 1", raw1.c0TxAlmFull); end
    drain(2, 410, 12, "ri_absorb");
  endtask

  initial begin
    d0c0 = 1'b0; d0c1 = 1'b0; d1c0 = 1'b0; d1c1 = 1'b0;
    raw0.reset = 1'b1; raw0.c0Tx = '0; raw0.c1Tx = '0; raw0.c2Tx = '0;
    raw1.reset = 1'b1; raw1.c0Tx = '0; raw1.c1Tx = '0; raw1.c2Tx = '0;
    buf0.c0TxAlmFull = 1'b0; buf0.c1TxAlmFull = 1'b0; buf0.c0Rx = '0; buf0.c1Rx = '0;
    buf1.c0TxAlmFull = 1'b0; buf1.c1TxAlmFull = 1'b0; buf1.c0Rx = '0; buf1.c1Rx = '0;
    test_reset();
    test_single();
    test_passthrough();
    test_burst_fill();
    test_steady_state();
    test_reset_mid_burst();
    test_register_inbound();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
